// File: rtl/fir_driver.sv
// Upstream driver for the 5-tap fir: loads the coefficient bank, then streams buffered samples.
// Define FIR_DRV_FIFO_EN for a 4-entry sample FIFO; otherwise a single holding register is used.
module fir_driver #(
  parameter int TAPS = 5,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic          start,
  input  logic          stop,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          fir_error,
  output logic [DW-1:0] data_in,
  output logic          coef_enable,
  output logic          sample_enable,
  output logic          busy,
  output logic          err,
  output logic [15:0]   sent_count
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, STREAM, FAULT} state_t;

  state_t        state, state_n;
  logic [DW-1:0] bank [8];
  logic [3:0]    idx, idx_n;
  logic [DW-1:0] data_n;
  logic          coef_n, sen_n, err_n, clr_cnt;
  logic          flush, pop, push;
  logic          buf_empty, buf_full;
  logic [DW-1:0] head;

  assign busy = (state == LOAD) || (state == GAP) || (state == STREAM);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) bank[i] <= '0;
    end else if (cfg_we && (state == IDLE || state == FAULT) && (32'(cfg_addr) < TAPS)) begin
      bank[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = data_in;
    coef_n  = 1'b0;
    sen_n   = 1'b0;
    err_n   = err;
    clr_cnt = 1'b0;
    flush   = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE, FAULT: begin
        if (start) begin
          state_n = LOAD;
          data_n  = bank[0];
          coef_n  = 1'b1;
          idx_n   = 4'd1;
          err_n   = 1'b0;
          clr_cnt = 1'b1;
        end
      end
      LOAD: begin
        if (idx == 4'(TAPS)) begin
          state_n = GAP;
          data_n  = '0;
        end else begin
          data_n = bank[idx[2:0]];
          coef_n = 1'b1;
          idx_n  = idx + 4'd1;
        end
      end
      GAP: state_n = STREAM;
      STREAM: begin
        if (!buf_empty) begin
          pop    = 1'b1;
          data_n = head;
          sen_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Fault and stop override whatever the active state decided this cycle.
    if (busy && (fir_error || stop)) begin
      state_n = fir_error ? FAULT : IDLE;
      err_n   = fir_error ? 1'b1 : err;
      data_n  = data_in;
      coef_n  = 1'b0;
      sen_n   = 1'b0;
      pop     = 1'b0;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      data_in       <= '0;
      coef_enable   <= 1'b0;
      sample_enable <= 1'b0;
      err           <= 1'b0;
      sent_count    <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      data_in       <= data_n;
      coef_enable   <= coef_n;
      sample_enable <= sen_n;
      err           <= err_n;
      if (clr_cnt)    sent_count <= '0;
      else if (sen_n) sent_count <= sent_count + 16'd1;
    end
  end

  assign push = s_valid && s_ready && !flush;

`ifdef FIR_DRV_FIFO_EN
  logic [DW-1:0] fifo [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;

  assign buf_empty = (count == 3'd0);
  assign buf_full  = (count == 3'd4);
  assign head      = fifo[rd_ptr];
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign s_ready   = (state != FAULT) && (!buf_full || pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= s_data;
        wr_ptr       <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end
`else
  logic [DW-1:0] hold;
  logic          full;

  assign buf_empty = !full;
  assign buf_full  = full;
  assign head      = hold;
  assign s_ready   = (state != FAULT) && !buf_full;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      full <= 1'b0;
    end else if (push) begin
      hold <= s_data;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fir_driver.sv
// Self-checking bench for fir_driver: scoreboard of expected coef/sample events versus observed ones.
module tb_fir_driver;

`ifdef FIR_DRV_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, cfg_we, start, stop, s_valid, fir_error;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data, s_data;
  logic        s_ready, coef_enable, sample_enable, busy, err;
  logic [7:0]  data_in;
  logic [15:0] sent_count;

  typedef struct packed { logic kind; logic [7:0] data; } ev_t;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic [7:0] bank_m [5];
  int   checks = 0;
  int   fails  = 0;
  int   both_high = 0;

  fir_driver #(.TAPS(5), .DW(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_error(fir_error), .data_in(data_in), .coef_enable(coef_enable),
    .sample_enable(sample_enable), .busy(busy), .err(err), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coef_enable)   obs_q.push_back('{kind: 1'b0, data: data_in});
    if (sample_enable) obs_q.push_back('{kind: 1'b1, data: data_in});
    if (coef_enable && sample_enable) both_high++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bank;
    for (int i = 0; i < 5; i++) exp_q.push_back('{kind: 1'b0, data: bank_m[i]});
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({data_in, coef_enable, sample_enable, busy, err, sent_count, s_ready} !==
        {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: got data=%h ce=%b se=%b busy=%b err=%b cnt=%0d rdy=%b, required 0s and rdy=1",
               data_in, coef_enable, sample_enable, busy, err, sent_count, s_ready);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_load_stream;
    ev_t e, o;
    int  acc = 0;
    for (int i = 0; i < 5; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = 8'(10 * (i + 1));
      bank_m[i] = cfg_data;
      tick();
    end
    cfg_we = 1'b0;
    push_bank();
    pulse_start();
    checks++;
    if (coef_enable !== 1'b1 || data_in !== 8'd10 || busy !== 1'b1) begin
      fails++;
      $display("FAIL load_first: got ce=%b data=%0d busy=%b, required ce=1 data=10 busy=1", coef_enable, data_in, busy);
    end
    repeat (5) tick();
    checks++;
    if (coef_enable !== 1'b0 || sample_enable !== 1'b0 || data_in !== 8'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL gap_cycle: got ce=%b se=%b data=%0d busy=%b, required 0 0 0 1", coef_enable, sample_enable, data_in, busy);
    end
    for (int c = 0; c < 40 && acc < 8; c++) begin
      s_valid = 1'b1; s_data = 8'd1;
      if (s_ready) begin exp_q.push_back('{kind: 1'b1, data: 8'd1}); acc++; end
      tick();
    end
    s_valid = 1'b0;
    for (int c = 0; c < 40 && sent_count != 16'd8; c++) tick();
    tick();
    checks++;
    if (sent_count !== 16'd8) begin
      fails++;
      $display("FAIL stream_count: got %0d, required 8", sent_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL load_stream_seq: got nothing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL load_stream_seq: got %h, required %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL load_stream_extra: got %0d extra events, required 0", obs_q.size());
    end
    obs_q.delete();
    pulse_stop();
  endtask

  task automatic test_back_to_back;
    ev_t e, o;
    int  acc = 0;
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1; s_data = 8'(8'hA0 + c);
      if (s_ready) begin exp_q.push_back('{kind: 1'b1, data: s_data}); acc++; end
      tick();
    end
    checks++;
    if (acc != DEPTH || s_ready !== 1'b0) begin
      fails++; $display("FAIL backpressure: got %0d accepts rdy=%b, required %0d accepts rdy=0", acc, s_ready, DEPTH);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_front('{kind: 1'b0, data: bank_m[4 - i]});
    pulse_start();
    repeat (6) tick();
    checks++;
    if (sample_enable !== 1'b0) begin
      fails++; $display("FAIL early_sample: got se=%b at start+7, required 0", sample_enable);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if (sample_enable !== 1'b1) begin
        fails++; $display("FAIL back_to_back_pulse%0d: got se=%b, required 1", i, sample_enable);
      end
    end
    tick();
    checks++;
    if (sample_enable !== 1'b0 || sent_count !== 16'(DEPTH)) begin
      fails++; $display("FAIL back_to_back_end: got se=%b cnt=%0d, required se=0 cnt=%0d", sample_enable, sent_count, DEPTH);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL back_to_back_seq: got nothing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL back_to_back_seq: got %h, required %h", o, e); end
      end
    end
    obs_q.delete();
    pulse_stop();
  endtask

  task automatic test_stop;
    ev_t e, o;
    logic hit = 1'b0;
    push_bank();
    s_valid = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      s_data = 8'(c + 1);
      if (s_ready) exp_q.push_back('{kind: 1'b1, data: s_data});
      tick();
      start = 1'b0;
      if (sent_count == 16'd3) begin hit = 1'b1; break; end
    end
    s_valid = 1'b0;
    checks++;
    if (!hit) begin fails++; $display("FAIL stop_reach3: got cnt=%0d, required 3 within budget", sent_count); end
    pulse_stop();
    checks++;
    if (sample_enable !== 1'b0 || busy !== 1'b0 || sent_count !== 16'd3) begin
      fails++; $display("FAIL stop_next: got se=%b busy=%b cnt=%0d, required 0 0 3", sample_enable, busy, sent_count);
    end
    repeat (5) tick();
    checks++;
    if (sent_count !== 16'd3 || s_ready !== 1'b1) begin
      fails++; $display("FAIL stop_idle: got cnt=%0d rdy=%b, required cnt=3 rdy=1", sent_count, s_ready);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL stop_seq: got nothing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL stop_seq: got %h, required %h", o, e); end
      end
    end
    exp_q.delete();
    checks++;
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL stop_extra: got %0d events after stop, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_fault;
    ev_t e, o;
    for (int i = 0; i < 3; i++) exp_q.push_back('{kind: 1'b0, data: bank_m[i]});
    pulse_start();
    repeat (2) tick();
    fir_error = 1'b1;
    tick();
    fir_error = 1'b0;
    checks++;
    if (coef_enable !== 1'b0 || sample_enable !== 1'b0 || err !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL fault_entry: got ce=%b se=%b err=%b rdy=%b busy=%b, required 0 0 1 0 0",
                        coef_enable, sample_enable, err, s_ready, busy);
    end
    push_bank();
    tick();
    pulse_start();
    checks++;
    if (err !== 1'b0 || coef_enable !== 1'b1) begin
      fails++; $display("FAIL fault_restart: got err=%b ce=%b, required err=0 ce=1", err, coef_enable);
    end
    repeat (10) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL fault_seq: got nothing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL fault_seq: got %h, required %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL fault_extra: got %0d extra events, required 0", obs_q.size());
    end
    obs_q.delete();
    pulse_stop();
  endtask

  task automatic test_protection;
    ev_t e, o;
    push_bank();
    pulse_start();
    repeat (6) tick();
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 8'hEE;
    tick();
    cfg_we = 1'b0;
    pulse_stop();
    cfg_we = 1'b1; cfg_addr = 3'd6; cfg_data = 8'h77;
    tick();
    cfg_we = 1'b0;
    push_bank();
    pulse_start();
    repeat (8) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL protect_seq: got nothing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL protect_seq: got %h, required %h", o, e); end
      end
    end
    obs_q.delete();
    pulse_stop();
  endtask

  task automatic test_reset_mid_load;
    ev_t e, o;
    for (int i = 0; i < 2; i++) exp_q.push_back('{kind: 1'b0, data: bank_m[i]});
    pulse_start();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({data_in, coef_enable, sample_enable, busy, err, sent_count, s_ready} !==
        {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_load: got data=%h ce=%b se=%b busy=%b err=%b cnt=%0d rdy=%b, required 0s and rdy=1",
               data_in, coef_enable, sample_enable, busy, err, sent_count, s_ready);
    end
    for (int i = 0; i < 5; i++) bank_m[i] = 8'h00;
    push_bank();
    pulse_start();
    repeat (8) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL reset_load_seq: got nothing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL reset_load_seq: got %h, required %h", o, e); end
      end
    end
    obs_q.delete();
    checks++;
    if (both_high != 0) begin
      fails++; $display("FAIL enables_exclusive: got %0d overlapping cycles, required 0", both_high);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; stop = 1'b0;
    s_valid = 1'b0; s_data = '0; fir_error = 1'b0;
    for (int i = 0; i < 5; i++) bank_m[i] = 8'h00;
    test_reset();
    test_load_stream();
    test_back_to_back();
    test_stop();
    test_fault();
    test_protection();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
